sipo_rx: RTL and testbench
==========================

// Module: sipo_rx
// PURPOSE
//   Serial-in/parallel-out receiver: the stage directly downstream of the piso serializer.
//   Reassembles the piso dataout bit stream into WIDTH-bit words.
//   Presents each word on a valid/ready output port.
//   Frames are marked by sin_start, which the sender drives from its own load strobe.
// PARAMETERS
//   WIDTH      8   data word width in bits (>=2)
//   MSB_FIRST  1   1: first received bit lands in dout[WIDTH-1]; 0: first bit lands in dout[0]
// PORTS
//   clk         in   1      single clock; all state updates on posedge clk
//   rst         in   1      synchronous, active-high reset
//   sin         in   1      serial data bit (from piso dataout)
//   sin_valid   in   1      sin holds a valid bit this cycle; low = stall, no shift
//   sin_start   in   1      qualified by sin_valid: this bit is the first bit of a new word
//   dout        out  WIDTH  assembled word; stable while dout_valid && !dout_ready
//   dout_valid  out  1      dout holds an unconsumed word
//   dout_ready  in   1      consumer accepts dout this cycle when dout_valid=1
//   overrun     out  1      sticky: a completed word was dropped because holding reg was full
//   parity_err  out  1      only with SIPO_PARITY_EN: sticky, received parity mismatched
// BEHAVIOUR
//   Reset (rst=1 at posedge): state=IDLE, bit count=0, shift reg=0.
//     dout=0, dout_valid=0, overrun=0, parity_err=0.
//     rst mid-word discards the partial word and any held word.
//   FSM IDLE:
//     sin_valid&&sin_start -> SHIFT; the bit is stored as bit 0 of the frame; count=1.
//     Bits with sin_start=0 are ignored.
//   FSM SHIFT:
//     Each sin_valid bit shifts in and count increments.
//     sin_valid=0 holds all state.
//   Restart: sin_valid&&sin_start in SHIFT abandons the partial word.
//     That bit becomes bit 0 of a new frame; count=1; no flag is raised.
//   Completion: on the edge sampling frame bit WIDTH-1 (parity bit when enabled):
//     FSM returns to IDLE; the word is offered to the holding register on that same edge.
//     Latency: dout_valid rises at the edge sampling the last bit (0 extra cycles).
//   Back-to-back: a sin_start bit on the cycle after completion is accepted from IDLE.
//     No gap cycle is required.
//   Holding register:
//     dout_valid&&dout_ready at an edge clears dout_valid.
//     If completion happens on that same edge, the new word loads and dout_valid stays 1.
//     Completion with dout_valid=1 and dout_ready=0: the new word is dropped,
//       the held word is kept, and overrun is set to 1.
//     overrun and parity_err clear only on rst.
//   Bit order:
//     MSB_FIRST=1: shift left, sin enters at LSB.
//     MSB_FIRST=0: shift right, sin enters at MSB.
//   Count width: $clog2(WIDTH+1) bits; the count never exceeds the frame length.
// CONFIGURATION
//   SIPO_PARITY_EN defined:
//     The frame is WIDTH data bits plus 1 even-parity bit.
//     FSM adds state PARITY after data bit WIDTH-1.
//     On completion, if ^{data,parity}!=0, parity_err is set to 1.
//     The word is still delivered.
//   SIPO_PARITY_EN undefined:
//     The frame is WIDTH bits, there is no PARITY state, and parity_err is tied to 0.
// STRUCTURE
//   sipo_pkg: state enum (S_IDLE, S_SHIFT, S_PARITY) and the function cnt_w(WIDTH).
//   Sub-module sipo_shreg:
//     Parameterised WIDTH and MSB_FIRST.
//     Shift register with en and clr inputs.
//     sipo_rx holds the FSM, counter, holding register and flags.
// TESTING
//   1 WIDTH=8, MSB_FIRST=1, dout_ready=1. sin_start on bit0, then bits 0,0,0,0,1,1,1,1 consecutive.
//     -> dout=8'h0F with dout_valid=1 for exactly 1 cycle, at the edge of the 8th bit.
//   2 Same word 8'hA5 with sin_valid low every other cycle.
//     -> dout=8'hA5 after 8 valid bits (15 cycles); state held during stalls.
//   3 dout_ready=0. Send 8'h3C then 8'hC3 back-to-back.
//     -> dout stays 8'h3C, overrun=1 after 2nd word.
//     Raise dout_ready -> dout_valid=0 next edge; overrun stays 1.
//   4 4 bits of a word, then sin_start with new word 8'h81.
//     -> dout=8'h81 only, overrun=0, no partial word delivered.
//   5 rst=1 after 5 bits, with a held word present.
//     -> next edge: dout=0, dout_valid=0, overrun=0.
//     A following 8'h55 frame is received correctly.
//   6 SIPO_PARITY_EN: send 8'h0F+parity 0 -> dout=8'h0F, parity_err=0.
//     Send 8'h0F+parity 1 -> dout=8'h0F, parity_err=1 (sticky).

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types for the sipo_rx serial receiver: FSM state encoding and counter width helper.
package sipo_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
  } state_e;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_shreg.sv
// Serial-to-parallel shift register; shreg_next is the value the register takes at the next edge.
module sipo_shreg #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             sin,
  output logic [WIDTH-1:0] shreg_next
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [WIDTH-1:0] base;

  // clr together with en starts a fresh frame: the incoming bit lands on an empty register.
  always_comb begin
    base    = clr ? '0 : shreg_q;
    shreg_d = base;
    if (en) begin
      if (MSB_FIRST != 0) shreg_d = {base[WIDTH-2:0], sin};
      else                shreg_d = {sin, base[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) shreg_q <= '0;
    else     shreg_q <= shreg_d;
  end

  assign shreg_next = shreg_d;

endmodule

// File: rtl/sipo_rx.sv
// Serial receiver reassembling WIDTH-bit words onto a valid/ready port.
// Define SIPO_PARITY_EN to append and check one even-parity bit per frame.
module sipo_rx
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sin_start,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overrun_q, overrun_d;
  logic             start;
  logic             complete;
  logic             shift_en;
  logic [WIDTH-1:0] word;

  assign start    = sin_valid && sin_start;
  assign shift_en = start || (sin_valid && (state_q == S_SHIFT));

  sipo_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk        (clk),
    .rst        (rst),
    .en         (shift_en),
    .clr        (start),
    .sin        (sin),
    .shreg_next (word)
  );

`ifdef SIPO_PARITY_EN
  logic parity_err_q, parity_err_d;
  logic parity_hit;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = overrun_q;
    complete     = 1'b0;
`ifdef SIPO_PARITY_EN
    parity_err_d = parity_err_q;
    parity_hit   = 1'b0;
`endif

    // A start bit always opens a new frame, abandoning any partial one.
    if (start) begin
      state_d = S_SHIFT;
      cnt_d   = CW'(1);
    end else if (sin_valid) begin
      case (state_q)
        S_SHIFT: begin
          if (cnt_q == LAST_DATA) begin
`ifdef SIPO_PARITY_EN
            state_d = S_PARITY;
            cnt_d   = CW'(WIDTH);
`else
            state_d  = S_IDLE;
            cnt_d    = '0;
            complete = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`ifdef SIPO_PARITY_EN
        S_PARITY: begin
          // Register is not shifting here, so word already holds the full data.
          state_d    = S_IDLE;
          cnt_d      = '0;
          complete   = 1'b1;
          parity_hit = ^{word, sin};
        end
`endif
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    if (complete) begin
      if (!dout_valid_q || dout_ready) begin
        dout_d       = word;
        dout_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end

`ifdef SIPO_PARITY_EN
    if (parity_hit) parity_err_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef SIPO_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) parity_err_q <= 1'b0;
    else     parity_err_q <= parity_err_d;
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: directed frame scenarios plus random bit streams against a bit-list model.
module tb_sipo_rx;

  localparam int WIDTH     = 8;
  localparam int MSB_FIRST = 1;
`ifdef SIPO_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sin = 1'b0;
  logic             sin_valid = 1'b0;
  logic             sin_start = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready = 1'b1;
  logic             overrun;
  logic             parity_err;

  sipo_rx #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) dut (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .sin_start  (sin_start),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model: the current frame is simply the list of bits received since its start bit.
  bit               m_bits[$];
  bit               m_in_frame = 1'b0;
  logic [WIDTH-1:0] m_dout     = '0;
  logic             m_valid    = 1'b0;
  logic             m_ovr      = 1'b0;
  logic             m_perr     = 1'b0;

  task automatic model_edge();
    int               ones;
    logic [WIDTH-1:0] w;
    bit               done;
    if (rst) begin
      m_bits.delete();
      m_in_frame = 1'b0;
      m_dout = '0; m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
      return;
    end
    done = 1'b0;
    w    = '0;
    if (sin_valid) begin
      if (sin_start) begin
        m_bits.delete();
        m_bits.push_back(sin);
        m_in_frame = 1'b1;
      end else if (m_in_frame) begin
        m_bits.push_back(sin);
      end
    end
    if (m_in_frame && m_bits.size() == FL) begin
      done = 1'b1;
      ones = 0;
      for (int i = 0; i < FL; i++) ones += int'(m_bits[i]);
      for (int i = 0; i < WIDTH; i++) begin
        if (MSB_FIRST != 0) w = WIDTH'(w * 2 + WIDTH'(m_bits[i]));
        else if (m_bits[i]) w = w | WIDTH'(1 << i);
      end
      if (FL > WIDTH && (ones % 2) == 1) m_perr = 1'b1;
      m_bits.delete();
      m_in_frame = 1'b0;
    end
    if (done) begin
      if (!m_valid || dout_ready) begin
        m_dout  = w;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && dout_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    assert (got === exp) checks_passed++;
    else $error("FAIL %s got %0h exp %0h", tag, got, exp);
  endtask

  task automatic check_all();
    check("dout_valid", 32'(dout_valid), 32'(m_valid));
    check("dout",       32'(dout),       32'(m_dout));
    check("overrun",    32'(overrun),    32'(m_ovr));
    check("parity_err", 32'(parity_err), 32'(m_perr));
  endtask

  task automatic step(input logic v, input logic s, input logic b, input logic r);
    sin_valid  = v;
    sin_start  = s;
    sin        = b;
    dout_ready = r;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input bit stall, input logic r,
                           input logic pbit);
    logic bv;
    for (int i = 0; i < WIDTH; i++) begin
      bv = (MSB_FIRST != 0) ? w[WIDTH-1-i] : w[i];
      if (stall && i > 0) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r);
      step(1'b1, (i == 0), bv, r);
    end
    if (FL > WIDTH) step(1'b1, 1'b0, pbit, r);
  endtask

  initial begin
    logic [WIDTH-1:0] rw;

    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("reset_dout", 32'(dout), 32'h0);
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b1, 1'b1);

    // 1: plain frame, consumer always ready; valid for one cycle only.
    send_word(8'h0F, 1'b0, 1'b1, ^8'h0F);
    check("t1_dout", 32'(dout), 32'h0F);
    check("t1_valid", 32'(dout_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t1_valid_drop", 32'(dout_valid), 32'h0);

    // 2: stalls between every bit.
    send_word(8'hA5, 1'b1, 1'b1, ^8'hA5);
    check("t2_dout", 32'(dout), 32'hA5);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // 3: consumer stalled, second word overruns.
    send_word(8'h3C, 1'b0, 1'b0, ^8'h3C);
    send_word(8'hC3, 1'b0, 1'b0, ^8'hC3);
    check("t3_dout_kept", 32'(dout), 32'h3C);
    check("t3_overrun", 32'(overrun), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t3_valid_clr", 32'(dout_valid), 32'h0);
    check("t3_overrun_sticky", 32'(overrun), 32'h1);

    // 4: restart mid-frame (after a reset to clear the sticky overrun).
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, (i == 0), 1'b1, 1'b1);
    send_word(8'h81, 1'b0, 1'b1, ^8'h81);
    check("t4_dout", 32'(dout), 32'h81);
    check("t4_overrun", 32'(overrun), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // 5: reset with a held word and a partial frame in flight.
    send_word(8'h99, 1'b0, 1'b0, ^8'h99);
    for (int i = 0; i < 5; i++) step(1'b1, (i == 0), 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    check("t5_rst_valid", 32'(dout_valid), 32'h0);
    check("t5_rst_dout", 32'(dout), 32'h0);
    send_word(8'h55, 1'b0, 1'b1, ^8'h55);
    check("t5_dout", 32'(dout), 32'h55);
    step(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef SIPO_PARITY_EN
    // 6: good then bad parity.
    send_word(8'h0F, 1'b0, 1'b1, 1'b0);
    check("t6_perr0", 32'(parity_err), 32'h0);
    send_word(8'h0F, 1'b0, 1'b1, 1'b1);
    check("t6_dout", 32'(dout), 32'h0F);
    check("t6_perr1", 32'(parity_err), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t6_perr_sticky", 32'(parity_err), 32'h1);
`endif

    // Back-to-back random words, then free-running random bit traffic.
    for (int n = 0; n < 20; n++) begin
      rw = WIDTH'($urandom);
      send_word(rw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)));
    end
    for (int n = 0; n < 600; n++) begin
      step(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
